// File: rtl/player_pkg.sv
// Shared types for the player mover slice: direction decode, FSM states and
// button bit positions.
// Optional feature macro: PLAYER_MOVER_DIAG_EN (diagonal decode of
// orthogonal two-button combinations).
package player_pkg;

  localparam int BTN_U = 3;
  localparam int BTN_D = 2;
  localparam int BTN_R = 1;
  localparam int BTN_L = 0;

  typedef enum logic [3:0] {
    DIR_NONE,
    DIR_U,
    DIR_D,
    DIR_R,
    DIR_L,
    DIR_UR,
    DIR_UL,
    DIR_DR,
    DIR_DL
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  // One-hot buttons give a cardinal direction; diagonals only exist when the
  // macro is defined, every other pattern means no movement.
  function automatic dir_t decodeDir(input logic [3:0] b);
    dir_t d;
    d = DIR_NONE;
    case (b)
      4'b1000: d = DIR_U;
      4'b0100: d = DIR_D;
      4'b0010: d = DIR_R;
      4'b0001: d = DIR_L;
`ifdef PLAYER_MOVER_DIAG_EN
      4'b1010: d = DIR_UR;
      4'b1001: d = DIR_UL;
      4'b0110: d = DIR_DR;
      4'b0101: d = DIR_DL;
`endif
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/player_mover_if.sv
// Command/status bundle between the button decoder, the player mover and the
// renderer. master drives commands and geometry, slave is the mover.
interface player_mover_if #(
  parameter int POS_W = 11
);
  logic [3:0]       btns;
  logic             upEnable;
  logic             downEnable;
  logic             rightEnable;
  logic             leftEnable;
  logic             wrapMode;
  logic             load;
  logic [POS_W-1:0] hStartPos;
  logic [POS_W-1:0] vStartPos;
  logic [POS_W-1:0] objWidth;
  logic [POS_W-1:0] objHeight;
  logic [POS_W-1:0] hPos;
  logic [POS_W-1:0] vPos;
  logic             moved;
  logic             blocked;

  modport master (
    output btns, upEnable, downEnable, rightEnable, leftEnable,
    output wrapMode, load, hStartPos, vStartPos, objWidth, objHeight,
    input  hPos, vPos, moved, blocked
  );

  modport slave (
    input  btns, upEnable, downEnable, rightEnable, leftEnable,
    input  wrapMode, load, hStartPos, vStartPos, objWidth, objHeight,
    output hPos, vPos, moved, blocked
  );
endinterface

// File: rtl/player_mover_axis_stepper.sv
// Combinational single-axis step: move by STEP inside 0..bound, snap to the
// bound when the full step would overshoot, then clamp or wrap at the edge.
module axis_stepper #(
  parameter int POS_W = 11,
  parameter int STEP  = 12
) (
  input  logic [POS_W-1:0] pos,
  input  logic             stepReq,
  input  logic             negDir,
  input  logic             enable,
  input  logic [POS_W-1:0] bound,
  input  logic             wrapMode,
  output logic [POS_W-1:0] nextPos,
  output logic             changed,
  output logic             blocked
);
  // Two guard bits: one for the sign, one so pos+STEP never overflows.
  localparam int XW = POS_W + 2;
  localparam logic signed [XW-1:0] STEP_S = XW'(STEP);

  logic signed [XW-1:0] posS;
  logic signed [XW-1:0] boundS;
  logic signed [XW-1:0] target;
  logic                 inRange;
  logic [POS_W-1:0]     edgePos;
  logic [POS_W-1:0]     oppPos;
  logic [POS_W-1:0]     cand;

  // Target position and the near/far bounds for the requested direction.
  always_comb begin
    posS    = signed'({2'b00, pos});
    boundS  = signed'({2'b00, bound});
    target  = negDir ? (posS - STEP_S) : (posS + STEP_S);
    inRange = !target[XW-1] && (target <= boundS);
    edgePos = negDir ? '0 : bound;
    oppPos  = negDir ? bound : '0;
  end

  // Resolve the step into a new position and exactly one status flag.
  always_comb begin
    nextPos = pos;
    changed = 1'b0;
    blocked = 1'b0;
    cand    = pos;
    if (stepReq) begin
      if (!enable) begin
        blocked = 1'b1;
      end else begin
        if (inRange)
          cand = target[POS_W-1:0];
        else if (pos != edgePos)
          cand = edgePos;
        else if (wrapMode)
          cand = oppPos;
        else
          cand = pos;
        nextPos = cand;
        changed = (cand != pos);
        blocked = (cand == pos);
      end
    end
  end
endmodule

// File: rtl/player_mover.sv
// Player rectangle position register with hold-to-repeat stepping,
// clamp/wrap edge handling, per-direction enables and position load.
// Optional feature macro: PLAYER_MOVER_DIAG_EN (diagonal moves).
module player_mover
  import player_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int POS_W      = 11,
  parameter int STEP       = 12,
  parameter int H_START    = 320,
  parameter int V_START    = 240,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4,
  parameter int CNT_W      = 8
) (
  input logic           btnClk,
  input logic           rst,
  player_mover_if.slave bus
);
  localparam logic [POS_W-1:0] H_RES_W   = POS_W'(H_RES);
  localparam logic [POS_W-1:0] V_RES_W   = POS_W'(V_RES);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PER - 1);

  state_t           state, stateNext;
  dir_t             dir, lastDir;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             stepReq;

  logic [POS_W-1:0] hPosQ, vPosQ;
  logic             movedQ, blockedQ;
  logic [POS_W-1:0] hBound, vBound;
  logic [POS_W-1:0] hLoad, vLoad;

  logic             hReq, hNeg, hEn;
  logic             vReq, vNeg, vEn;
  logic [POS_W-1:0] hNext, vNext;
  logic             hChg, hBlk, vChg, vBlk;

  // Legal top-left ranges and the clamped load targets.
  always_comb begin
    hBound = (bus.objWidth  >= H_RES_W) ? '0 : (H_RES_W - bus.objWidth);
    vBound = (bus.objHeight >= V_RES_W) ? '0 : (V_RES_W - bus.objHeight);
    hLoad  = (bus.hStartPos > hBound) ? hBound : bus.hStartPos;
    vLoad  = (bus.vStartPos > vBound) ? vBound : bus.vStartPos;
    dir    = decodeDir(bus.btns);
  end

  // Repeat FSM: decides whether this edge takes a step.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stepReq   = 1'b0;
    if (dir == DIR_NONE) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else if (state == IDLE || dir != lastDir) begin
      stepReq   = 1'b1;
      stateNext = DELAY;
      cntNext   = '0;
    end else if (state == DELAY) begin
      if (cnt == DLY_LAST) begin
        stepReq   = 1'b1;
        stateNext = REPEAT;
        cntNext   = '0;
      end else begin
        cntNext = cnt + 1'b1;
      end
    end else begin
      if (cnt == PER_LAST) begin
        stepReq = 1'b1;
        cntNext = '0;
      end else begin
        cntNext = cnt + 1'b1;
      end
    end
    if (bus.load) begin
      stepReq   = 1'b0;
      stateNext = IDLE;
      cntNext   = '0;
    end
  end

  // Route the step request to the axis or axes the direction touches.
  always_comb begin
    hReq = 1'b0; hNeg = 1'b0; hEn = 1'b0;
    vReq = 1'b0; vNeg = 1'b0; vEn = 1'b0;
    case (dir)
      DIR_U: begin vReq = stepReq; vNeg = 1'b1; vEn = bus.upEnable;    end
      DIR_D: begin vReq = stepReq; vNeg = 1'b0; vEn = bus.downEnable;  end
      DIR_R: begin hReq = stepReq; hNeg = 1'b0; hEn = bus.rightEnable; end
      DIR_L: begin hReq = stepReq; hNeg = 1'b1; hEn = bus.leftEnable;  end
`ifdef PLAYER_MOVER_DIAG_EN
      DIR_UR: begin
        vReq = stepReq; vNeg = 1'b1; vEn = bus.upEnable;
        hReq = stepReq; hNeg = 1'b0; hEn = bus.rightEnable;
      end
      DIR_UL: begin
        vReq = stepReq; vNeg = 1'b1; vEn = bus.upEnable;
        hReq = stepReq; hNeg = 1'b1; hEn = bus.leftEnable;
      end
      DIR_DR: begin
        vReq = stepReq; vNeg = 1'b0; vEn = bus.downEnable;
        hReq = stepReq; hNeg = 1'b0; hEn = bus.rightEnable;
      end
      DIR_DL: begin
        vReq = stepReq; vNeg = 1'b0; vEn = bus.downEnable;
        hReq = stepReq; hNeg = 1'b1; hEn = bus.leftEnable;
      end
`endif
      default: ;
    endcase
  end

  axis_stepper #(.POS_W(POS_W), .STEP(STEP)) hAxis (
    .pos(hPosQ), .stepReq(hReq), .negDir(hNeg), .enable(hEn),
    .bound(hBound), .wrapMode(bus.wrapMode),
    .nextPos(hNext), .changed(hChg), .blocked(hBlk)
  );

  axis_stepper #(.POS_W(POS_W), .STEP(STEP)) vAxis (
    .pos(vPosQ), .stepReq(vReq), .negDir(vNeg), .enable(vEn),
    .bound(vBound), .wrapMode(bus.wrapMode),
    .nextPos(vNext), .changed(vChg), .blocked(vBlk)
  );

  // Position, status pulses and FSM registers; load overrides any step.
  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      hPosQ    <= POS_W'(H_START);
      vPosQ    <= POS_W'(V_START);
      movedQ   <= 1'b0;
      blockedQ <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      lastDir  <= DIR_NONE;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      lastDir <= dir;
      if (bus.load) begin
        hPosQ    <= hLoad;
        vPosQ    <= vLoad;
        movedQ   <= (hLoad != hPosQ) || (vLoad != vPosQ);
        blockedQ <= 1'b0;
      end else begin
        hPosQ    <= hNext;
        vPosQ    <= vNext;
        // A diagonal that moves on either axis is not reported as blocked.
        movedQ   <= hChg || vChg;
        blockedQ <= (hBlk || vBlk) && !(hChg || vChg);
      end
    end
  end

  assign bus.hPos    = hPosQ;
  assign bus.vPos    = vPosQ;
  assign bus.moved   = movedQ;
  assign bus.blocked = blockedQ;
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: reset, hold-to-repeat timing, clamp,
// wrap, load clamping, enables, load priority, diagonal decode and reset
// during auto-repeat.
module tb_player_mover;
  logic btnClk = 1'b0;
  logic rst    = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  player_mover_if #(.POS_W(11)) bus ();

  player_mover #(
    .H_RES(640), .V_RES(480), .POS_W(11), .STEP(12),
    .H_START(320), .V_START(240), .REPEAT_DLY(8), .REPEAT_PER(4), .CNT_W(8)
  ) dut (
    .btnClk(btnClk),
    .rst(rst),
    .bus(bus)
  );

  always #5 btnClk = ~btnClk;

  task automatic tick;
    @(posedge btnClk);
    #1;
  endtask

  task automatic doLoad(input int h, input int v);
    bus.hStartPos = 11'(h);
    bus.vStartPos = 11'(v);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset;
    bus.btns = 4'b0000;
    bus.upEnable = 1'b1; bus.downEnable = 1'b1;
    bus.rightEnable = 1'b1; bus.leftEnable = 1'b1;
    bus.wrapMode = 1'b0; bus.load = 1'b0;
    bus.hStartPos = 11'd0; bus.vStartPos = 11'd0;
    bus.objWidth = 11'd32; bus.objHeight = 11'd32;
    rst = 1'b0;
    repeat (3) tick();
    tests++; if (bus.hPos !== 11'd320) begin fails++; $display("FAIL reset_h got=%0d exp=320", bus.hPos); end
    tests++; if (bus.vPos !== 11'd240) begin fails++; $display("FAIL reset_v got=%0d exp=240", bus.vPos); end
    tests++; if (bus.moved !== 1'b0) begin fails++; $display("FAIL reset_moved got=%0b exp=0", bus.moved); end
    tests++; if (bus.blocked !== 1'b0) begin fails++; $display("FAIL reset_blocked got=%0b exp=0", bus.blocked); end
    @(negedge btnClk);
    rst = 1'b1;
    tick();
    tests++; if (bus.hPos !== 11'd320 || bus.moved !== 1'b0) begin fails++; $display("FAIL reset_idle h=%0d moved=%0b exp 320/0", bus.hPos, bus.moved); end
  endtask

  task automatic test_hold_repeat;
    bus.btns = 4'b0001;
    tick();
    tests++; if (bus.hPos !== 11'd308 || bus.moved !== 1'b1) begin fails++; $display("FAIL hold_first h=%0d moved=%0b exp 308/1", bus.hPos, bus.moved); end
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++; if (bus.hPos !== 11'd308 || bus.moved !== 1'b0) begin fails++; $display("FAIL hold_delay[%0d] h=%0d moved=%0b exp 308/0", i, bus.hPos, bus.moved); end
    end
    tick();
    tests++; if (bus.hPos !== 11'd296 || bus.moved !== 1'b1) begin fails++; $display("FAIL hold_second h=%0d moved=%0b exp 296/1", bus.hPos, bus.moved); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.hPos !== 11'd296) begin fails++; $display("FAIL hold_per1[%0d] h=%0d exp 296", i, bus.hPos); end
    end
    tick();
    tests++; if (bus.hPos !== 11'd284) begin fails++; $display("FAIL hold_third h=%0d exp 284", bus.hPos); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.hPos !== 11'd284) begin fails++; $display("FAIL hold_per2[%0d] h=%0d exp 284", i, bus.hPos); end
    end
    tick();
    tests++; if (bus.hPos !== 11'd272) begin fails++; $display("FAIL hold_fourth h=%0d exp 272", bus.hPos); end
    bus.btns = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (bus.hPos !== 11'd272 || bus.moved !== 1'b0 || bus.blocked !== 1'b0) begin fails++; $display("FAIL hold_release[%0d] h=%0d m=%0b b=%0b exp 272/0/0", i, bus.hPos, bus.moved, bus.blocked); end
    end
  endtask

  task automatic test_clamp;
    doLoad(600, 240);
    tests++; if (bus.hPos !== 11'd600 || bus.moved !== 1'b1) begin fails++; $display("FAIL clamp_load h=%0d moved=%0b exp 600/1", bus.hPos, bus.moved); end
    bus.btns = 4'b0010;
    tick();
    tests++; if (bus.hPos !== 11'd608 || bus.moved !== 1'b1 || bus.blocked !== 1'b0) begin fails++; $display("FAIL clamp_snap h=%0d m=%0b b=%0b exp 608/1/0", bus.hPos, bus.moved, bus.blocked); end
    bus.btns = 4'b0000;
    tick();
    bus.btns = 4'b0010;
    tick();
    tests++; if (bus.hPos !== 11'd608 || bus.blocked !== 1'b1 || bus.moved !== 1'b0) begin fails++; $display("FAIL clamp_block h=%0d m=%0b b=%0b exp 608/0/1", bus.hPos, bus.moved, bus.blocked); end
    tick();
    tests++; if (bus.blocked !== 1'b0) begin fails++; $display("FAIL clamp_pulse b=%0b exp 0", bus.blocked); end
    bus.btns = 4'b0000;
    tick();
  endtask

  task automatic test_wrap;
    bus.wrapMode = 1'b1;
    bus.btns = 4'b0010;
    tick();
    tests++; if (bus.hPos !== 11'd0 || bus.moved !== 1'b1) begin fails++; $display("FAIL wrap_right h=%0d moved=%0b exp 0/1", bus.hPos, bus.moved); end
    bus.btns = 4'b0000;
    tick();
    bus.btns = 4'b0001;
    tick();
    tests++; if (bus.hPos !== 11'd608 || bus.moved !== 1'b1) begin fails++; $display("FAIL wrap_left h=%0d moved=%0b exp 608/1", bus.hPos, bus.moved); end
    bus.btns = 4'b0000;
    tick();
    doLoad(320, 0);
    bus.btns = 4'b1000;
    tick();
    tests++; if (bus.vPos !== 11'd448 || bus.moved !== 1'b1) begin fails++; $display("FAIL wrap_up v=%0d moved=%0b exp 448/1", bus.vPos, bus.moved); end
    bus.btns = 4'b0000;
    bus.wrapMode = 1'b0;
    tick();
  endtask

  task automatic test_load_clamp;
    doLoad(1000, 1000);
    tests++; if (bus.hPos !== 11'd608 || bus.vPos !== 11'd448) begin fails++; $display("FAIL load_clamp pos=(%0d,%0d) exp (608,448)", bus.hPos, bus.vPos); end
    bus.objWidth = 11'd700;
    doLoad(100, 100);
    tests++; if (bus.hPos !== 11'd0 || bus.vPos !== 11'd100) begin fails++; $display("FAIL load_wide pos=(%0d,%0d) exp (0,100)", bus.hPos, bus.vPos); end
    bus.objWidth = 11'd32;
    doLoad(0, 100);
    tests++; if (bus.moved !== 1'b0) begin fails++; $display("FAIL load_same moved=%0b exp 0", bus.moved); end
  endtask

  task automatic test_disable_priority;
    doLoad(320, 240);
    bus.rightEnable = 1'b0;
    bus.btns = 4'b0010;
    tick();
    tests++; if (bus.hPos !== 11'd320 || bus.blocked !== 1'b1 || bus.moved !== 1'b0) begin fails++; $display("FAIL disabled h=%0d m=%0b b=%0b exp 320/0/1", bus.hPos, bus.moved, bus.blocked); end
    bus.btns = 4'b0000;
    bus.rightEnable = 1'b1;
    tick();
    bus.btns = 4'b0010;
    bus.hStartPos = 11'd100; bus.vStartPos = 11'd50;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.btns = 4'b0000;
    tests++; if (bus.hPos !== 11'd100 || bus.vPos !== 11'd50 || bus.moved !== 1'b1) begin fails++; $display("FAIL load_prio pos=(%0d,%0d) m=%0b exp (100,50)/1", bus.hPos, bus.vPos, bus.moved); end
    tick();
    tests++; if (bus.hPos !== 11'd100) begin fails++; $display("FAIL load_prio_after h=%0d exp 100", bus.hPos); end
  endtask

  task automatic test_diag;
    int expH, expV;
    logic expM;
    doLoad(320, 240);
    tick();
    bus.btns = 4'b1010;
    tick();
`ifdef PLAYER_MOVER_DIAG_EN
    expH = 332; expV = 228; expM = 1'b1;
`else
    expH = 320; expV = 240; expM = 1'b0;
`endif
    tests++; if (bus.hPos !== 11'(expH) || bus.vPos !== 11'(expV) || bus.moved !== expM) begin fails++; $display("FAIL diag_ur pos=(%0d,%0d) m=%0b exp (%0d,%0d)/%0b", bus.hPos, bus.vPos, bus.moved, expH, expV, expM); end
    bus.btns = 4'b0000;
    tick();
    bus.btns = 4'b1100;
    tick();
    tests++; if (bus.hPos !== 11'(expH) || bus.vPos !== 11'(expV) || bus.moved !== 1'b0 || bus.blocked !== 1'b0) begin fails++; $display("FAIL diag_opposite pos=(%0d,%0d) m=%0b b=%0b exp (%0d,%0d)/0/0", bus.hPos, bus.vPos, bus.moved, bus.blocked, expH, expV); end
    bus.btns = 4'b0000;
    tick();
  endtask

  task automatic test_reset_in_repeat;
    doLoad(320, 240);
    bus.btns = 4'b0100;
    tick();
    tests++; if (bus.vPos !== 11'd252) begin fails++; $display("FAIL rr_first v=%0d exp 252", bus.vPos); end
    repeat (8) tick();
    tests++; if (bus.vPos !== 11'd264) begin fails++; $display("FAIL rr_second v=%0d exp 264", bus.vPos); end
    repeat (4) tick();
    tests++; if (bus.vPos !== 11'd276) begin fails++; $display("FAIL rr_third v=%0d exp 276", bus.vPos); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    tests++; if (bus.hPos !== 11'd320 || bus.vPos !== 11'd240 || bus.moved !== 1'b0) begin fails++; $display("FAIL rr_async pos=(%0d,%0d) m=%0b exp (320,240)/0", bus.hPos, bus.vPos, bus.moved); end
    @(negedge btnClk);
    rst = 1'b1;
    tick();
    tests++; if (bus.vPos !== 11'd252 || bus.moved !== 1'b1) begin fails++; $display("FAIL rr_restart v=%0d m=%0b exp 252/1", bus.vPos, bus.moved); end
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++; if (bus.vPos !== 11'd252) begin fails++; $display("FAIL rr_delay[%0d] v=%0d exp 252", i, bus.vPos); end
    end
    tick();
    tests++; if (bus.vPos !== 11'd264) begin fails++; $display("FAIL rr_redelay v=%0d exp 264", bus.vPos); end
    bus.btns = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_clamp();
    test_wrap();
    test_load_clamp();
    test_disable_priority();
    test_diag();
    test_reset_in_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
